// File: rtl/cpu_run_pkg.sv
// Shared state encoding and run-mode constants for the CPU run controller.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUNN = 2'b10;

  // The reserved encoding 11 behaves exactly like free-run.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_FREE : m;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle registered history, combinational pulse.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_reg;

  always_ff @(posedge clk) begin
    if (rst) sig_reg <= 1'b0;
    else     sig_reg <= sig;
  end

  assign pulse = sig & ~sig_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset hold, free-run / single-step / run-N sessions,
// halt, abort and watchdog handling, with a saturating enabled-cycle counter.
module cpu_run_ctrl #(
  parameter int CYCLE_W    = 16,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [CYCLE_W-1:0] n_cycles,
  input  logic               step,
  input  logic               cpu_halt,
  output logic               cpu_rst,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  import cpu_run_pkg::*;

  localparam int               RST_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RST_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CNT_SAT   = '1;
  localparam logic [CYCLE_W-1:0] CNT_LIMIT = CYCLE_W'(MAX_CYCLES);

  state_t             state_reg, state_next;
  logic [RST_W-1:0]   rst_cnt_reg, rst_cnt_next;
  logic [CYCLE_W-1:0] cnt_reg, cnt_next;
  logic [CYCLE_W-1:0] n_reg, n_next;
  logic [1:0]         mode_reg, mode_next;
  logic               timeout_reg, timeout_next;
  logic               step_pulse;
  logic [CYCLE_W-1:0] cnt_inc;
  logic               hit_max, hit_n;

  rise_detect u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (step),
    .pulse (step_pulse)
  );

  // Value the counter takes if this cycle is an enabled one.
  assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
  assign hit_max = (cnt_inc >= CNT_LIMIT);
  assign hit_n   = (cnt_inc >= n_reg);

  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = rst_cnt_reg;
    cnt_next     = cnt_reg;
    n_next       = n_reg;
    mode_next    = mode_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_next    = norm_mode(mode);
          n_next       = n_cycles;
          cnt_next     = '0;
          timeout_next = 1'b0;
          rst_cnt_next = RST_LOAD;
          state_next   = ST_RESET;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_next = ST_DONE;
        end else if (rst_cnt_reg == '0) begin
          if (mode_reg == MODE_STEP)                    state_next = ST_STEP_WAIT;
          else if (mode_reg == MODE_RUNN && n_reg == '0) state_next = ST_DONE;
          else                                          state_next = ST_RUN;
        end else begin
          rst_cnt_next = rst_cnt_reg - 1'b1;
        end
      end
      ST_RUN: begin
        // The enabled cycle always counts, whatever ends the session.
        cnt_next = cnt_inc;
        if (abort || cpu_halt) begin
          state_next = ST_DONE;
        end else begin
          case (mode_reg)
            MODE_RUNN: if (hit_n) state_next = ST_DONE;
            MODE_STEP: begin
              if (hit_max) begin
                state_next   = ST_DONE;
                timeout_next = 1'b1;
              end else begin
                state_next = ST_STEP_WAIT;
              end
            end
            default: begin
              if (hit_max) begin
                state_next   = ST_DONE;
                timeout_next = 1'b1;
              end
            end
          endcase
        end
      end
      ST_STEP_WAIT: begin
        if (abort)           state_next = ST_DONE;
        else if (step_pulse) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rst_cnt_reg <= '0;
      cnt_reg     <= '0;
      n_reg       <= '0;
      mode_reg    <= MODE_FREE;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rst_cnt_reg <= rst_cnt_next;
      cnt_reg     <= cnt_next;
      n_reg       <= n_next;
      mode_reg    <= mode_next;
      timeout_reg <= timeout_next;
    end
  end

  assign cpu_rst   = (state_reg == ST_IDLE) || (state_reg == ST_RESET);
  assign cpu_en    = (state_reg == ST_RUN);
  assign busy      = (state_reg == ST_RESET) || (state_reg == ST_RUN) ||
                     (state_reg == ST_STEP_WAIT);
  assign done      = (state_reg == ST_DONE);
  assign timeout   = timeout_reg;
  assign cycle_cnt = cnt_reg;

endmodule
